sequence_feeder: RTL and testbench



---
 rtl/sequence_feeder_if.sv | 10 +
 rtl/sequence_feeder.sv | 249 ++++++++++++++++++++++++
 tb/tb_sequence_feeder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sequence_feeder_if.sv
// Word bus carrying packed 2-bit bases into the sequence feeder.
// The master offers 64-bit words; the slave accepts on in_valid & in_ready.
interface sequence_feeder_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sequence_feeder.sv
// Loads an alignment job's query into a flat register, streams the target one
// base per clock to the scoring array, then waits for the array to drain.
module sequence_feeder #(
    parameter int LENGTH     = 128,
    parameter int LOG_LENGTH = $clog2(LENGTH + 1),
    parameter int TLEN_WIDTH = 16,
    parameter int PIPE_SLACK = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LOG_LENGTH-1:0]   query_len,
    input  logic [TLEN_WIDTH-1:0]   target_len,
    sequence_feeder_if.slave        bus,
    output logic [2*LENGTH-1:0]     query,
    output logic [LOG_LENGTH-1:0]   output_select,
    output logic                    en_out,
    output logic [1:0]              data_out,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    typedef enum logic [1:0] {IDLE, LOAD_Q, STREAM_T, DRAIN} state_t;

    state_t                  state_r, state_n;
    logic [LOG_LENGTH-1:0]   qlen_r, qlen_n;
    logic [2*LENGTH-1:0]     query_r, query_n;
    logic [LOG_LENGTH-1:0]   qwords_r, qwords_n;
    logic [LOG_LENGTH-1:0]   qidx_r, qidx_n;
    logic [TLEN_WIDTH-1:0]   twords_r, twords_n;
    logic [TLEN_WIDTH-1:0]   bases_left_r, bases_left_n;
    logic [63:0]             shift_r, shift_n;
    logic [4:0]              shift_cnt_r, shift_cnt_n;
    logic [63:0]             hold_r, hold_n;
    logic                    hold_v_r, hold_v_n;
    logic                    started_r, started_n;
    logic [LOG_LENGTH:0]     drain_r, drain_n;
    logic                    en_out_r, en_out_n;
    logic [1:0]              data_out_r, data_out_n;
    logic                    in_ready_r, in_ready_n;
    logic                    busy_r, busy_n;
    logic                    done_r, done_n;
    logic                    err_r, err_n;

    logic                    accept_s;
    logic                    emit_s;
    logic [1:0]              base_s;
    logic                    bad_start_s;
    logic [2*LENGTH-1:0]     qword_s;

    assign accept_s    = bus.in_valid & in_ready_r;
    assign bad_start_s = (query_len == {LOG_LENGTH{1'b0}}) ||
                         (query_len > LOG_LENGTH'(LENGTH)) ||
                         (target_len == {TLEN_WIDTH{1'b0}});

    // Place the incoming query word at its slot, zeroing bases beyond query_len.
    always_comb begin
        qword_s = '0;
        for (int j = 0; j < LENGTH; j++) begin
            if (((j / 32) == int'(qidx_r)) && (j < int'(qlen_r))) begin
                qword_s[2*j +: 2] = bus.in_data[2*(j % 32) +: 2];
            end else begin
                qword_s[2*j +: 2] = 2'b00;
            end
        end
    end

    // Next-state and next-output logic for the job FSM and target buffer.
    always_comb begin
        state_n      = state_r;
        qlen_n       = qlen_r;
        query_n      = query_r;
        qwords_n     = qwords_r;
        qidx_n       = qidx_r;
        twords_n     = twords_r;
        bases_left_n = bases_left_r;
        shift_n      = shift_r;
        shift_cnt_n  = shift_cnt_r;
        hold_n       = hold_r;
        hold_v_n     = hold_v_r;
        started_n    = started_r;
        drain_n      = drain_r;
        en_out_n     = 1'b0;
        data_out_n   = data_out_r;
        done_n       = 1'b0;
        err_n        = 1'b0;
        emit_s       = 1'b0;
        base_s       = 2'b00;

        case (state_r)
            IDLE: begin
                if (start && bad_start_s) begin
                    err_n = 1'b1;
                end else if (start) begin
                    qlen_n       = query_len;
                    query_n      = '0;
                    qwords_n     = LOG_LENGTH'(({1'b0, query_len} + (LOG_LENGTH+1)'(31)) >> 5);
                    twords_n     = TLEN_WIDTH'(({1'b0, target_len} + (TLEN_WIDTH+1)'(31)) >> 5);
                    bases_left_n = target_len;
                    qidx_n       = {LOG_LENGTH{1'b0}};
                    shift_cnt_n  = 5'd0;
                    hold_v_n     = 1'b0;
                    started_n    = 1'b0;
                    state_n      = LOAD_Q;
                end else begin
                    state_n = IDLE;
                end
            end
            LOAD_Q: begin
                if (accept_s) begin
                    query_n = query_r | qword_s;
                    qidx_n  = qidx_r + LOG_LENGTH'(1);
                    if (qidx_r == (qwords_r - LOG_LENGTH'(1))) begin
                        state_n = STREAM_T;
                    end else begin
                        state_n = LOAD_Q;
                    end
                end else begin
                    state_n = LOAD_Q;
                end
            end
            STREAM_T: begin
                // Source priority: current word, then holding word, then the bus directly.
                if (shift_cnt_r != 5'd0) begin
                    emit_s      = 1'b1;
                    base_s      = shift_r[1:0];
                    shift_n     = shift_r >> 2;
                    shift_cnt_n = shift_cnt_r - 5'd1;
                    if (accept_s) begin
                        hold_n   = bus.in_data;
                        hold_v_n = 1'b1;
                        twords_n = twords_r - TLEN_WIDTH'(1);
                    end else begin
                        hold_v_n = hold_v_r;
                    end
                end else if (hold_v_r) begin
                    emit_s      = 1'b1;
                    base_s      = hold_r[1:0];
                    shift_n     = hold_r >> 2;
                    shift_cnt_n = 5'd31;
                    hold_v_n    = 1'b0;
                end else if (accept_s) begin
                    emit_s      = 1'b1;
                    base_s      = bus.in_data[1:0];
                    shift_n     = bus.in_data >> 2;
                    shift_cnt_n = 5'd31;
                    twords_n    = twords_r - TLEN_WIDTH'(1);
                    started_n   = 1'b1;
                end else if (started_r) begin
                    err_n       = 1'b1;
                    shift_cnt_n = 5'd0;
                    hold_v_n    = 1'b0;
                    started_n   = 1'b0;
                    state_n     = IDLE;
                end else begin
                    state_n = STREAM_T;
                end

                if (emit_s) begin
                    en_out_n     = 1'b1;
                    data_out_n   = base_s;
                    bases_left_n = bases_left_r - TLEN_WIDTH'(1);
                    if (bases_left_r == TLEN_WIDTH'(1)) begin
                        shift_cnt_n = 5'd0;
                        hold_v_n    = 1'b0;
                        started_n   = 1'b0;
                        drain_n     = (LOG_LENGTH+1)'(qlen_r) + (LOG_LENGTH+1)'(PIPE_SLACK);
                        state_n     = DRAIN;
                    end else begin
                        drain_n = drain_r;
                    end
                end else begin
                    en_out_n = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_r == (LOG_LENGTH+1)'(1)) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    drain_n = drain_r - (LOG_LENGTH+1)'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        in_ready_n = (state_n == LOAD_Q) ||
                     ((state_n == STREAM_T) && !hold_v_n && (twords_n != {TLEN_WIDTH{1'b0}}));
        busy_n     = (state_n != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            qlen_r       <= '0;
            query_r      <= '0;
            qwords_r     <= '0;
            qidx_r       <= '0;
            twords_r     <= '0;
            bases_left_r <= '0;
            shift_r      <= '0;
            shift_cnt_r  <= 5'd0;
            hold_r       <= '0;
            hold_v_r     <= 1'b0;
            started_r    <= 1'b0;
            drain_r      <= '0;
            en_out_r     <= 1'b0;
            data_out_r   <= 2'b00;
            in_ready_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_n;
            qlen_r       <= qlen_n;
            query_r      <= query_n;
            qwords_r     <= qwords_n;
            qidx_r       <= qidx_n;
            twords_r     <= twords_n;
            bases_left_r <= bases_left_n;
            shift_r      <= shift_n;
            shift_cnt_r  <= shift_cnt_n;
            hold_r       <= hold_n;
            hold_v_r     <= hold_v_n;
            started_r    <= started_n;
            drain_r      <= drain_n;
            en_out_r     <= en_out_n;
            data_out_r   <= data_out_n;
            in_ready_r   <= in_ready_n;
            busy_r       <= busy_n;
            done_r       <= done_n;
            err_r        <= err_n;
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign query          = query_r;
    assign output_select  = qlen_r;
    assign en_out         = en_out_r;
    assign data_out       = data_out_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign err            = err_r;

endmodule

// File: tb/tb_sequence_feeder.sv
// Scenario-based bench for sequence_feeder: expected bases are queued as target
// words are offered and compared against the bases the DUT emits.
module tb_sequence_feeder;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   query_len;
    logic [15:0]  target_len;
    logic [255:0] query;
    logic [7:0]   output_select;
    logic         en_out;
    logic [1:0]   data_out;
    logic         busy, done, err;

    sequence_feeder_if bus();

    sequence_feeder #(.LENGTH(128), .LOG_LENGTH(8), .TLEN_WIDTH(16), .PIPE_SLACK(2)) dut (
        .clk(clk), .rst(rst), .start(start), .query_len(query_len), .target_len(target_len),
        .bus(bus), .query(query), .output_select(output_select), .en_out(en_out),
        .data_out(data_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [63:0] words[$];
    logic [1:0]  exp_q[$];
    logic [1:0]  obs_q[$];
    logic [63:0] qw_arr[4];
    int cyc, acc_cnt, en_cnt, first_en, last_en, done_cnt, done_cyc, err_cnt;

    task automatic clear_obs();
        words.delete(); exp_q.delete(); obs_q.delete();
        acc_cnt = 0; en_cnt = 0; first_en = -1; last_en = -1;
        done_cnt = 0; done_cyc = -1; err_cnt = 0;
    endtask

    // One clock: offer the head word, advance, then record what the DUT shows.
    task automatic tick();
        bit acc;
        bus.in_valid = (words.size() > 0);
        bus.in_data  = (words.size() > 0) ? words[0] : 64'd0;
        acc = bus.in_valid && (bus.in_ready === 1'b1);
        @(posedge clk); #1;
        cyc++;
        if (acc) begin void'(words.pop_front()); acc_cnt++; end
        if (en_out === 1'b1) begin
            obs_q.push_back(data_out); en_cnt++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
        end
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (err === 1'b1) err_cnt++;
    endtask

    task automatic push_target(input logic [63:0] w, input int nb);
        words.push_back(w);
        for (int k = 0; k < nb; k++) exp_q.push_back(w[2*k +: 2]);
    endtask

    function automatic logic [255:0] model_query(input int qlen);
        logic [255:0] r;
        logic [63:0]  w;
        r = '0;
        for (int j = 0; j < qlen; j++) begin
            w = qw_arr[j / 32];
            r[2*j +: 2] = w[2*(j % 32) +: 2];
        end
        return r;
    endfunction

    task automatic start_job(input int q, input int t);
        query_len = 8'(q); target_len = 16'(t); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > 0 || err_cnt > 0) break;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; tick(); tick();
        checks++; if ({en_out, data_out, bus.in_ready, busy, done, err} !== 7'd0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000000", {en_out, data_out, bus.in_ready, busy, done, err}); end
        checks++; if (query !== 256'd0) begin errors++; $display("FAIL reset_query: got %h expected 0", query); end
        checks++; if (output_select !== 8'd0) begin errors++; $display("FAIL reset_outsel: got %0d expected 0", output_select); end
        rst = 1'b1; tick();
    endtask

    task automatic test_basic();
        logic [1:0] o, e;
        clear_obs();
        qw_arr[0] = 64'hFFFF_FFFF_FFFF_FFE4;
        words.push_back(qw_arr[0]);
        push_target(64'hA5A5_A5A5_A5A5_A51B, 4);
        start_job(4, 4);
        checks++; if ({busy, bus.in_ready} !== 2'b11) begin errors++; $display("FAIL basic_start: busy/in_ready got %b expected 11", {busy, bus.in_ready}); end
        wait_end(200); tick(); tick();
        checks++; if (done_cnt !== 1 || err_cnt !== 0) begin errors++; $display("FAIL basic_done: done=%0d err=%0d expected 1 0", done_cnt, err_cnt); end
        checks++; if (en_cnt !== 4 || last_en - first_en + 1 !== 4) begin errors++; $display("FAIL basic_en: count %0d span %0d expected 4 4", en_cnt, last_en - first_en + 1); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_nbases: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL basic_base: got %b expected %b", o, e); end
        end
        checks++; if (query !== 256'hE4) begin errors++; $display("FAIL basic_query: got %h expected e4", query); end
        checks++; if (output_select !== 8'd4) begin errors++; $display("FAIL basic_outsel: got %0d expected 4", output_select); end
        checks++; if (done_cyc - last_en !== 6) begin errors++; $display("FAIL basic_drain: got %0d expected 6", done_cyc - last_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: busy got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] o, e;
        clear_obs();
        for (int w = 0; w < 4; w++) begin qw_arr[w] = {$urandom, $urandom}; words.push_back(qw_arr[w]); end
        push_target({$urandom, $urandom}, 32);
        push_target({$urandom, $urandom}, 32);
        push_target({$urandom, $urandom}, 6);
        start_job(128, 70);
        wait_end(600); tick(); tick();
        checks++; if (acc_cnt !== 7) begin errors++; $display("FAIL b2b_words: got %0d expected 7", acc_cnt); end
        checks++; if (en_cnt !== 70 || last_en - first_en + 1 !== 70) begin errors++; $display("FAIL b2b_en: count %0d span %0d expected 70 70", en_cnt, last_en - first_en + 1); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_nbases: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL b2b_base: got %b expected %b", o, e); end
        end
        checks++; if (query !== model_query(128)) begin errors++; $display("FAIL b2b_query: got %h expected %h", query, model_query(128)); end
        checks++; if (done_cnt !== 1 || err_cnt !== 0) begin errors++; $display("FAIL b2b_done: done=%0d err=%0d expected 1 0", done_cnt, err_cnt); end
        checks++; if (done_cyc - last_en !== 130) begin errors++; $display("FAIL b2b_drain: got %0d expected 130", done_cyc - last_en); end
    endtask

    task automatic test_underrun();
        logic [1:0] o, e;
        clear_obs();
        qw_arr[0] = {$urandom, $urandom};
        words.push_back(qw_arr[0]);
        push_target({$urandom, $urandom}, 32);
        start_job(8, 64);
        wait_end(200); tick(); tick();
        checks++; if (err_cnt !== 1 || done_cnt !== 0) begin errors++; $display("FAIL under_pulse: err=%0d done=%0d expected 1 0", err_cnt, done_cnt); end
        checks++; if (en_cnt !== 32) begin errors++; $display("FAIL under_en: got %0d expected 32", en_cnt); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL under_base: got %b expected %b", o, e); end
        end
        checks++; if ({busy, bus.in_ready} !== 2'b00) begin errors++; $display("FAIL under_idle: busy/in_ready got %b expected 00", {busy, bus.in_ready}); end
    endtask

    task automatic test_illegal();
        int ql[3] = '{0, 129, 4};
        int tl[3] = '{4, 4, 0};
        for (int i = 0; i < 3; i++) begin
            clear_obs();
            start_job(ql[i], tl[i]);
            checks++; if ({err, bus.in_ready, busy} !== 3'b100) begin errors++; $display("FAIL illegal_%0d: err/in_ready/busy got %b expected 100", i, {err, bus.in_ready, busy}); end
            tick();
            checks++; if ({err, bus.in_ready} !== 2'b00) begin errors++; $display("FAIL illegal_pulse_%0d: err/in_ready got %b expected 00", i, {err, bus.in_ready}); end
        end
        checks++; if (output_select !== 8'd8) begin errors++; $display("FAIL illegal_hold: outsel got %0d expected 8", output_select); end
    endtask

    task automatic test_drain_start();
        clear_obs();
        qw_arr[0] = {$urandom, $urandom};
        words.push_back(qw_arr[0]);
        push_target({$urandom, $urandom}, 4);
        start_job(4, 4);
        for (int i = 0; i < 60; i++) begin
            if (last_en >= 0 && en_out === 1'b0) break;
            tick();
        end
        query_len = 8'd4; target_len = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        wait_end(100);
        for (int i = 0; i < 10; i++) tick();
        checks++; if (done_cnt !== 1 || err_cnt !== 0) begin errors++; $display("FAIL drain_start: done=%0d err=%0d expected 1 0", done_cnt, err_cnt); end
        checks++; if ({busy, bus.in_ready} !== 2'b00) begin errors++; $display("FAIL drain_idle: busy/in_ready got %b expected 00", {busy, bus.in_ready}); end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        qw_arr[0] = {$urandom, $urandom};
        words.push_back(qw_arr[0]);
        push_target({$urandom, $urandom}, 32);
        push_target({$urandom, $urandom}, 32);
        start_job(8, 64);
        for (int i = 0; i < 100; i++) begin
            if (en_cnt >= 10) break;
            tick();
        end
        checks++; if (en_out !== 1'b1) begin errors++; $display("FAIL rstmid_stream: en_out got %b expected 1", en_out); end
        words.delete();
        rst = 1'b0; tick();
        checks++; if ({en_out, data_out, bus.in_ready, busy, done, err} !== 7'd0) begin errors++; $display("FAIL rstmid_ctrl: got %b expected 0000000", {en_out, data_out, bus.in_ready, busy, done, err}); end
        checks++; if (query !== 256'd0 || output_select !== 8'd0) begin errors++; $display("FAIL rstmid_query: query %h outsel %0d expected 0 0", query, output_select); end
        checks++; if (done_cnt !== 0 || err_cnt !== 0) begin errors++; $display("FAIL rstmid_pulse: done=%0d err=%0d expected 0 0", done_cnt, err_cnt); end
        rst = 1'b1; tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; query_len = 8'd0; target_len = 16'd0;
        bus.in_valid = 1'b0; bus.in_data = 64'd0;
        cyc = 0;
        clear_obs();
        test_reset();
        test_basic();
        test_back_to_back();
        test_underrun();
        test_illegal();
        test_drain_start();
        test_reset_mid();
        test_basic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
